// File: rtl/parallel_to_serial.sv
// Purpose : serializes WIDTH-bit words MSB first on serial_out, enable qualifies each bit; optional even-parity bit (P2S_PARITY_EN).
// Latency : MSB appears the cycle after an IDLE accept; one bit per clock, gap-free back-to-back via a one-word holding register.
// Backpres: ready = !hold_valid; a load seen while ready is low is dropped, so the producer holds load until ready.
module parallel_to_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             serial_out,
    output logic             enable,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 2);

`ifdef P2S_PARITY_EN
    // The parity bit occupies one extra bit time after the data bits.
    localparam int LAST_I = WIDTH;
`else
    localparam int LAST_I = WIDTH - 1;
`endif
    localparam logic [CW-1:0] LAST = CW'(LAST_I);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic [WIDTH-1:0] hold, hold_nxt;
    logic             hold_valid, hold_valid_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             accept;
    logic             last_bit;

`ifdef P2S_PARITY_EN
    // Parity is captured with the word so it survives the shifting of sh.
    logic             par, par_nxt;
    logic             par_hold, par_hold_nxt;
`endif

    // Handshake and final-bit qualifiers, all from registered state or the load input.
    always_comb begin
        ready    = !hold_valid;
        accept   = load && !hold_valid;
        last_bit = (state == SHIFT) && (cnt == LAST);
    end

    // Next-state, datapath update and output decode.
    always_comb begin
        state_nxt      = state;
        sh_nxt         = sh;
        hold_nxt       = hold;
        hold_valid_nxt = hold_valid;
        cnt_nxt        = cnt;
`ifdef P2S_PARITY_EN
        par_nxt        = par;
        par_hold_nxt   = par_hold;
`endif
        serial_out     = 1'b0;
        enable         = 1'b0;
        done           = 1'b0;
        busy           = hold_valid;

        unique case (state)
            IDLE: begin
                // A word accepted here goes straight into sh, not via hold.
                if (accept) begin
                    sh_nxt    = data_in;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
`ifdef P2S_PARITY_EN
                    par_nxt   = ^data_in;
`endif
                end
            end

            SHIFT: begin
                enable = 1'b1;
                busy   = 1'b1;
                done   = last_bit;
`ifdef P2S_PARITY_EN
                serial_out = (cnt == LAST) ? par : sh[WIDTH-1];
`else
                serial_out = sh[WIDTH-1];
`endif
                sh_nxt  = sh << 1;
                cnt_nxt = cnt + CW'(1);

                if (last_bit) begin
                    cnt_nxt = '0;
                    if (hold_valid) begin
                        // Held word starts in the very next cycle; ready is low
                        // on this edge so no new word can collide with it.
                        sh_nxt         = hold;
                        hold_valid_nxt = 1'b0;
`ifdef P2S_PARITY_EN
                        par_nxt        = par_hold;
`endif
                    end else if (accept) begin
                        // Load arriving on the closing edge bypasses hold.
                        sh_nxt  = data_in;
`ifdef P2S_PARITY_EN
                        par_nxt = ^data_in;
`endif
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (accept) begin
                    hold_nxt       = data_in;
                    hold_valid_nxt = 1'b1;
`ifdef P2S_PARITY_EN
                    par_hold_nxt   = ^data_in;
`endif
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any word in flight or held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sh         <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            cnt        <= '0;
`ifdef P2S_PARITY_EN
            par        <= 1'b0;
            par_hold   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            sh         <= sh_nxt;
            hold       <= hold_nxt;
            hold_valid <= hold_valid_nxt;
            cnt        <= cnt_nxt;
`ifdef P2S_PARITY_EN
            par        <= par_nxt;
            par_hold   <= par_hold_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: word-queue reference model checked every cycle,
// plus directed literal checks of the serial stream and a deserializing consumer.
// Build with P2S_PARITY_EN defined to exercise the parity variant.
module tb_parallel_to_serial;

    localparam int W = 8;
`ifdef P2S_PARITY_EN
    localparam int NB = W + 1;
    localparam logic [17:0] EXP_BB = {8'hD5, 1'b1, 8'h3C, 1'b0};
    localparam logic [17:0] EXP_81 = {9'd0, 8'h81, 1'b0};
    localparam logic [15:0] RX_D5 = 16'h01AB;
    localparam logic [15:0] RX_3C = 16'h0078;
    localparam logic [15:0] RX_81 = 16'h0102;
`else
    localparam int NB = W;
    localparam logic [17:0] EXP_BB = {2'b00, 8'hD5, 8'h3C};
    localparam logic [17:0] EXP_81 = {10'd0, 8'h81};
    localparam logic [15:0] RX_D5 = 16'h00D5;
    localparam logic [15:0] RX_3C = 16'h003C;
    localparam logic [15:0] RX_81 = 16'h0081;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         load = 1'b0;
    logic         ready, serial_out, enable, done, busy;

    int tests = 0;
    int fails = 0;

    // Reference model: words in flight (front = transmitting, second = held),
    // and the bit position within the front word.
    logic [W-1:0] mq[$];
    int           pos = 0;

    // Consumer: collects each word's bits (including parity) into rx_q.
    logic [15:0] acc;
    logic [15:0] rx_q[$];

    logic [17:0] exp_bb;
    logic [17:0] exp_81;

    parallel_to_serial #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load       (load),
        .ready      (ready),
        .serial_out (serial_out),
        .enable     (enable),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (enable) begin
            if (done) begin
                rx_q.push_back({acc[14:0], serial_out});
                acc <= '0;
            end else begin
                acc <= {acc[14:0], serial_out};
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        pos = 0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_step();
        bit acc_w;
        if (!reset) begin
            model_clear();
        end else begin
            acc_w = load && (mq.size() < 2);
            if (mq.size() > 0) begin
                pos++;
                if (pos == NB) begin
                    void'(mq.pop_front());
                    pos = 0;
                end
            end
            if (acc_w) mq.push_back(data_in);
        end
    endtask

    task automatic model_compare();
        logic [W-1:0] w;
        logic         e_en, e_bit, e_done;
        e_en   = (mq.size() > 0);
        e_bit  = 1'b0;
        e_done = 1'b0;
        if (e_en) begin
            w      = mq[0];
            e_bit  = (pos < W) ? w[W-1-pos] : ^w;
            e_done = (pos == NB - 1);
        end
        chk("model ready", {31'd0, ready}, {31'd0, mq.size() < 2});
        chk("model enable", {31'd0, enable}, {31'd0, e_en});
        chk("model serial_out", {31'd0, serial_out}, {31'd0, e_bit});
        chk("model done", {31'd0, done}, {31'd0, e_done});
        chk("model busy", {31'd0, busy}, {31'd0, e_en});
    endtask

    // One clock: wait to the falling edge, account for the rising edge before it, compare.
    task automatic tick();
        @(negedge clk);
        model_step();
        model_compare();
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " ready"}, {31'd0, ready}, 32'd1);
        chk({nm, " enable"}, {31'd0, enable}, 32'd0);
        chk({nm, " serial_out"}, {31'd0, serial_out}, 32'd0);
        chk({nm, " done"}, {31'd0, done}, 32'd0);
        chk({nm, " busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int base;
        exp_bb = EXP_BB;
        exp_81 = EXP_81;
        #1 reset = 1'b0;
        model_clear();

        // Reset held with random inputs, then the first cycle after release.
        for (int i = 0; i < 3; i++) begin
            load    = 1'($urandom);
            data_in = W'($urandom);
            tick();
            chk_idle("in_reset");
        end
        load  = 1'b0;
        reset = 1'b1;
        tick();
        chk_idle("after_release");

        // Single word D5 from IDLE.
        base    = rx_q.size();
        load    = 1'b1;
        data_in = 8'hD5;
        for (int i = 0; i < NB; i++) begin
            tick();
            if (i == 0) load = 1'b0;
            chk("single bit", {31'd0, serial_out}, {31'd0, exp_bb[2*NB-1-i]});
            chk("single enable", {31'd0, enable}, 32'd1);
            chk("single done", {31'd0, done}, {31'd0, i == NB - 1});
        end
        tick();
        chk_idle("single_end");
        chk("single rx count", rx_q.size(), base + 1);
        chk("single rx word", {16'd0, rx_q[base]}, {16'd0, RX_D5});

        // Back-to-back D5 then 3C, with a dropped FF while hold is full.
        base    = rx_q.size();
        load    = 1'b1;
        data_in = 8'hD5;
        for (int i = 0; i < 2 * NB; i++) begin
            tick();
            chk("b2b bit", {31'd0, serial_out}, {31'd0, exp_bb[2*NB-1-i]});
            chk("b2b enable", {31'd0, enable}, 32'd1);
            chk("b2b done", {31'd0, done}, {31'd0, (i == NB - 1) || (i == 2 * NB - 1)});
            chk("b2b ready", {31'd0, ready}, {31'd0, !(i >= 2 && i <= NB - 1)});
            if (i == 0) begin
                load = 1'b0;
            end else if (i == 1) begin
                load = 1'b1; data_in = 8'h3C;
            end else if (i <= 4) begin
                load = 1'b1; data_in = 8'hFF;
            end else begin
                load = 1'b0;
            end
        end
        tick();
        chk_idle("b2b_end");
        chk("b2b rx count", rx_q.size(), base + 2);
        chk("b2b rx word0", {16'd0, rx_q[base]}, {16'd0, RX_D5});
        chk("b2b rx word1", {16'd0, rx_q[base+1]}, {16'd0, RX_3C});

        // Reset after three bits of A5, then a clean 81.
        base    = rx_q.size();
        load    = 1'b1;
        data_in = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) load = 1'b0;
        end
        @(posedge clk);
        #2 reset = 1'b0;
        model_clear();
        #1;
        chk("async reset enable", {31'd0, enable}, 32'd0);
        chk("async reset serial_out", {31'd0, serial_out}, 32'd0);
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset ready", {31'd0, ready}, 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_idle("mid_reset_release");
        load    = 1'b1;
        data_in = 8'h81;
        for (int i = 0; i < NB; i++) begin
            tick();
            if (i == 0) load = 1'b0;
            chk("post reset bit", {31'd0, serial_out}, {31'd0, exp_81[NB-1-i]});
            chk("post reset done", {31'd0, done}, {31'd0, i == NB - 1});
        end
        tick();
        chk("post reset rx count", rx_q.size(), base + 1);
        chk("post reset rx word", {16'd0, rx_q[base]}, {16'd0, RX_81});

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                @(posedge clk);
                #2 reset = 1'b0;
                model_clear();
                tick();
                reset = 1'b1;
            end else begin
                load    = ($urandom_range(0, 2) != 0);
                data_in = W'($urandom);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
